// File: rtl/program_loader.sv
`default_nettype none
// ============================================================================
// Module   : program_loader
// Purpose  : Boot-time instruction-memory loader. Receives a framed byte
//            stream (SYNC, count hi/lo, N big-endian words, checksum), writes
//            each word to consecutive instruction-memory addresses from 0 and
//            releases the CPU controller from reset once the checksum matches.
// Ports    : Clk, Rst (async, active-low)
//            ByteIn/ByteValid/ByteReady : byte stream, valid/ready handshake
//            Restart                    : re-arm request (RUN/ERROR only)
//            IMemAddr/IMemData/IMemWrite: instruction-memory write port
//            CpuRstN                    : registered active-low CPU reset
//            Done/Error                 : RUN / ERROR indicators
//            WordCount                  : words written in current frame
//            StateOut                   : current state encoding
// Revision : 1.0 - initial release
// ============================================================================
module program_loader #(
  parameter int         ADDR_W = 8,
  parameter logic [7:0] SYNC   = 8'hA5
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic [7:0]        ByteIn,
  input  logic              ByteValid,
  output logic              ByteReady,
  input  logic              Restart,
  output logic [ADDR_W-1:0] IMemAddr,
  output logic [15:0]       IMemData,
  output logic              IMemWrite,
  output logic              CpuRstN,
  output logic              Done,
  output logic              Error,
  output logic [ADDR_W:0]   WordCount,
  output logic [2:0]        StateOut
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CNT_HI  = 3'd1,
    S_CNT_LO  = 3'd2,
    S_DATA_HI = 3'd3,
    S_DATA_LO = 3'd4,
    S_CHECK   = 3'd5,
    S_RUN     = 3'd6,
    S_ERROR   = 3'd7
  } state_e;

  // Largest legal word count; held one bit wider than N so 2**ADDR_W fits.
  localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_W;

  state_e            state_q, state_d;
  logic [7:0]        sum_q, sum_d;
  logic [7:0]        cnt_hi_q, cnt_hi_d;
  logic [15:0]       n_q, n_d;
  logic [7:0]        hi_q, hi_d;
  logic [ADDR_W:0]   wc_q, wc_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       data_q, data_d;
  logic              wr_q, wr_d;
  logic              cpu_rst_n_q, cpu_rst_n_d;

  logic              accept;
  logic [15:0]       n_rx;
  logic [ADDR_W:0]   wc_inc;

  assign ByteReady = (state_q != S_RUN) && (state_q != S_ERROR);
  assign accept    = ByteValid && ByteReady;
  assign n_rx      = {cnt_hi_q, ByteIn};
  assign wc_inc    = wc_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    sum_d    = sum_q;
    cnt_hi_d = cnt_hi_q;
    n_d      = n_q;
    hi_d     = hi_q;
    wc_d     = wc_q;
    addr_d   = addr_q;
    data_d   = data_q;
    wr_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept && (ByteIn == SYNC)) begin
          state_d = S_CNT_HI;
          wc_d    = '0;
          sum_d   = '0;
        end
      end
      S_CNT_HI: begin
        if (accept) begin
          cnt_hi_d = ByteIn;
          sum_d    = sum_q + ByteIn;
          state_d  = S_CNT_LO;
        end
      end
      S_CNT_LO: begin
        if (accept) begin
          n_d   = n_rx;
          sum_d = sum_q + ByteIn;
          if ((n_rx == 16'd0) || ({1'b0, n_rx} > MAX_WORDS)) begin
            state_d = S_ERROR;
          end else begin
            state_d = S_DATA_HI;
          end
        end
      end
      S_DATA_HI: begin
        if (accept) begin
          hi_d    = ByteIn;
          sum_d   = sum_q + ByteIn;
          state_d = S_DATA_LO;
        end
      end
      S_DATA_LO: begin
        // The write is registered here so it appears in the following
        // cycle, while the FSM is already back in a receiving state.
        if (accept) begin
          sum_d   = sum_q + ByteIn;
          wr_d    = 1'b1;
          data_d  = {hi_q, ByteIn};
          addr_d  = wc_q[ADDR_W-1:0];
          wc_d    = wc_inc;
          state_d = (16'(wc_inc) == n_q) ? S_CHECK : S_DATA_HI;
        end
      end
      S_CHECK: begin
        if (accept) begin
          state_d = (ByteIn == sum_q) ? S_RUN : S_ERROR;
        end
      end
      S_RUN, S_ERROR: begin
        if (Restart) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Registered from the next state so release coincides with the first
    // RUN cycle and re-assertion with the Restart edge.
    cpu_rst_n_d = (state_d == S_RUN);
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q     <= S_IDLE;
      sum_q       <= '0;
      cnt_hi_q    <= '0;
      n_q         <= '0;
      hi_q        <= '0;
      wc_q        <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      wr_q        <= 1'b0;
      cpu_rst_n_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sum_q       <= sum_d;
      cnt_hi_q    <= cnt_hi_d;
      n_q         <= n_d;
      hi_q        <= hi_d;
      wc_q        <= wc_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      wr_q        <= wr_d;
      cpu_rst_n_q <= cpu_rst_n_d;
    end
  end

  assign IMemAddr  = addr_q;
  assign IMemData  = data_q;
  assign IMemWrite = wr_q;
  assign CpuRstN   = cpu_rst_n_q;
  assign Done      = (state_q == S_RUN);
  assign Error     = (state_q == S_ERROR);
  assign WordCount = wc_q;
  assign StateOut  = state_q;

endmodule
`default_nettype wire

// File: tb/tb_program_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_program_loader
// Purpose  : Self-checking bench for program_loader. Frames are built in the
//            bench, a frame-level parser predicts the memory writes and final
//            outcome, and a monitor compares each write strobe against the
//            predicted queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_program_loader;

  localparam int ADDR_W = 8;

  logic              Clk = 1'b0;
  logic              Rst = 1'b0;
  logic [7:0]        ByteIn = 8'h00;
  logic              ByteValid = 1'b0;
  logic              ByteReady;
  logic              Restart = 1'b0;
  logic [ADDR_W-1:0] IMemAddr;
  logic [15:0]       IMemData;
  logic              IMemWrite;
  logic              CpuRstN;
  logic              Done;
  logic              Error;
  logic [ADDR_W:0]   WordCount;
  logic [2:0]        StateOut;

  program_loader #(.ADDR_W(ADDR_W), .SYNC(8'hA5)) dut (
    .Clk(Clk), .Rst(Rst), .ByteIn(ByteIn), .ByteValid(ByteValid),
    .ByteReady(ByteReady), .Restart(Restart), .IMemAddr(IMemAddr),
    .IMemData(IMemData), .IMemWrite(IMemWrite), .CpuRstN(CpuRstN),
    .Done(Done), .Error(Error), .WordCount(WordCount), .StateOut(StateOut)
  );

  always #5 Clk = ~Clk;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_addr[$];
  int exp_data[$];
  logic prev_wr = 1'b0;
  bit   rnd_restart = 1'b0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every write strobe must match the next prediction.
  always @(negedge Clk) begin
    if (Rst) begin
      if (IMemWrite) begin
        chk("strobe_one_cycle", prev_wr, 0);
        if (exp_addr.size() == 0) begin
          chk("unexpected_write", 1, 0);
        end else begin
          chk("wr_addr", IMemAddr, exp_addr.pop_front());
          chk("wr_data", IMemData, exp_data.pop_front());
        end
      end
      prev_wr = IMemWrite;
    end else begin
      prev_wr = 1'b0;
    end
  end

  // Frame-level reference: locate SYNC, read the count, walk the words and
  // compare the trailing byte with the mod-256 sum.
  task automatic model_frame(input logic [7:0] s[$], output int exp_state,
                             output int exp_wc);
    int i = 0;
    int n, sum, hi, lo;
    while (s[i] != 8'hA5) i++;
    hi = s[i+1];
    lo = s[i+2];
    n   = hi * 256 + lo;
    sum = hi + lo;
    if (n == 0 || n > (1 << ADDR_W)) begin
      exp_state = 7;
      exp_wc    = 0;
      return;
    end
    for (int w = 0; w < n; w++) begin
      hi = s[i+3+2*w];
      lo = s[i+4+2*w];
      exp_addr.push_back(w);
      exp_data.push_back(hi * 256 + lo);
      sum += hi + lo;
    end
    exp_wc = n;
    lo = s[i+3+2*n];
    exp_state = (lo == (sum % 256)) ? 6 : 7;
  endtask

  task automatic make_frame(input int n, input bit corrupt, output logic [7:0] q[$]);
    int sum;
    logic [7:0] b;
    q.delete();
    q.push_back(8'hA5);
    b = 8'(n >> 8);  q.push_back(b); sum = b;
    b = 8'(n);       q.push_back(b); sum += b;
    for (int k = 0; k < 2*n; k++) begin
      b = 8'($urandom_range(0, 255));
      q.push_back(b);
      sum += b;
    end
    b = 8'(sum) + (corrupt ? 8'd1 : 8'd0);
    q.push_back(b);
  endtask

  // Called at a negedge; returns at the negedge after the transfer edge.
  task automatic send_byte(input logic [7:0] b, input int maxgap);
    int g = $urandom_range(0, maxgap);
    int t = 0;
    if (g > 0) begin
      ByteValid = 1'b0;
      repeat (g) @(negedge Clk);
    end
    ByteValid = 1'b1;
    ByteIn    = b;
    Restart   = rnd_restart ? 1'($urandom_range(0, 1)) : 1'b0;
    while (!ByteReady && t < 20) begin
      @(negedge Clk);
      t++;
    end
    if (!ByteReady) chk("byte_ready_timeout", ByteReady, 1);
    chk("cpu_held_in_reset", CpuRstN, 0);
    @(negedge Clk);
    Restart = 1'b0;
  endtask

  task automatic run_frame(input logic [7:0] q[$], input int maxgap, input string tag);
    int es, ew;
    model_frame(q, es, ew);
    foreach (q[k]) send_byte(q[k], maxgap);
    ByteValid = 1'b0;
    Restart   = 1'b0;
    chk({tag, "_state"}, StateOut, es);
    chk({tag, "_done"}, Done, (es == 6));
    chk({tag, "_error"}, Error, (es == 7));
    chk({tag, "_cpurstn"}, CpuRstN, (es == 6));
    chk({tag, "_ready"}, ByteReady, 0);
    chk({tag, "_wordcount"}, WordCount, ew);
    chk({tag, "_writes_left"}, exp_addr.size(), 0);
  endtask

  task automatic do_restart();
    Restart = 1'b1;
    @(negedge Clk);
    Restart = 1'b0;
    chk("restart_state", StateOut, 0);
    chk("restart_cpurstn", CpuRstN, 0);
    chk("restart_ready", ByteReady, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] f1[$];
    logic [7:0] f[$];
    logic [7:0] garbage[$];
    f1      = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hC0};
    garbage = '{8'h00, 8'hFF, 8'h5A};

    // Reset state
    repeat (3) @(negedge Clk);
    chk("rst_state", StateOut, 0);
    chk("rst_cpurstn", CpuRstN, 0);
    chk("rst_ready", ByteReady, 1);
    chk("rst_done", Done, 0);
    chk("rst_error", Error, 0);
    chk("rst_wr", IMemWrite, 0);
    chk("rst_wc", WordCount, 0);
    chk("rst_addr", IMemAddr, 0);
    Rst = 1'b1;
    @(negedge Clk);

    // 1. Normal frame
    run_frame(f1, 0, "s1");
    chk("s1_last_data", IMemData, 16'hABCD);
    do_restart();

    // 2. Garbage before sync
    foreach (garbage[k]) begin
      send_byte(garbage[k], 0);
      chk("s2_garbage_idle", StateOut, 0);
    end
    run_frame(f1, 0, "s2");
    do_restart();

    // 3. Bad checksum
    f = f1;
    f[7] = 8'hC1;
    run_frame(f, 0, "s3");
    do_restart();

    // 4. Count bounds
    f = '{8'hA5, 8'h00, 8'h00};
    run_frame(f, 0, "s4_zero");
    do_restart();
    f = '{8'hA5, 8'h01, 8'h01};
    run_frame(f, 0, "s4_257");
    do_restart();
    make_frame(256, 1'b0, f);
    run_frame(f, 0, "s4_256");
    chk("s4_last_addr", IMemAddr, 8'hFF);
    do_restart();

    // 5. Gaps, ignored Restart during reception, random frames
    run_frame(f1, 5, "s5_gaps");
    do_restart();
    rnd_restart = 1'b1;
    for (int r = 0; r < 12; r++) begin
      make_frame($urandom_range(1, 12), ($urandom_range(0, 3) == 0), f);
      run_frame(f, 5, "s5_rand");
      do_restart();
    end
    rnd_restart = 1'b0;

    // 6. Async reset while in DATA_LO of the second word
    exp_addr.push_back(0);
    exp_data.push_back(16'h1234);
    for (int k = 0; k < 6; k++) send_byte(f1[k], 0);
    ByteValid = 1'b0;
    chk("s6_in_data_lo", StateOut, 4);
    #2;
    Rst = 1'b0;
    #1;
    chk("s6_async_state", StateOut, 0);
    chk("s6_async_wr", IMemWrite, 0);
    chk("s6_async_cpurstn", CpuRstN, 0);
    chk("s6_async_wc", WordCount, 0);
    chk("s6_async_data", IMemData, 0);
    chk("s6_async_ready", ByteReady, 1);
    chk("s6_writes_left", exp_addr.size(), 0);
    repeat (2) @(negedge Clk);
    Rst = 1'b1;
    @(negedge Clk);
    run_frame(f1, 2, "s6_after");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/program_loader.md
Name: program_loader

Overview:
- Boot-time instruction-memory loader for the 16-bit CPU.
- Receives a framed byte stream over a valid/ready interface and assembles big-endian 16-bit instruction words.
- Writes each word to consecutive instruction-memory addresses starting at 0.
- Holds the CPU controller in reset (its active-low Rst input) until a complete frame passes its checksum, then releases it.

Parameters:
- ADDR_W, 8, instruction-memory address width; maximum program length is 2**ADDR_W words.
- SYNC, 8'hA5, frame start byte.

Ports:
- Clk  input  1  system clock; all state changes on rising edge.
- Rst  input  1  asynchronous, active-low reset.
- ByteIn  input  8  stream data byte.
- ByteValid  input  1  ByteIn valid.
- ByteReady  output  1  loader can accept a byte; transfer occurs when ByteValid && ByteReady at a rising edge.
- Restart  input  1  synchronous re-arm request; honoured only in RUN or ERROR.
- IMemAddr  output  ADDR_W  instruction-memory write address.
- IMemData  output  16  instruction-memory write data.
- IMemWrite  output  1  one-cycle write strobe.
- CpuRstN  output  1  active-low reset to the CPU controller; registered.
- Done  output  1  high in RUN.
- Error  output  1  high in ERROR.
- WordCount  output  ADDR_W+1  number of words written in the current frame.
- StateOut  output  3  current state encoding.

Behaviour:
- Frame format, in order:
  - SYNC byte.
  - Count high byte, then count low byte (N, 16 bits).
  - N words, high byte first.
  - One checksum byte: 8-bit modulo-256 sum of the two count bytes and all 2N data bytes. SYNC is excluded.
- States (StateOut): IDLE 000, CNT_HI 001, CNT_LO 010, DATA_HI 011, DATA_LO 100, CHECK 101, RUN 110, ERROR 111.
- ByteReady is combinational from state: 1 in IDLE through CHECK, 0 in RUN and ERROR.
- Async reset (Rst=0), effective immediately regardless of state or Clk:
  - state IDLE; IMemWrite 0; IMemAddr 0; IMemData 0; WordCount 0; running sum 0; CpuRstN 0.
  - Done and Error 0; ByteReady 1.
- IDLE:
  - Accepted byte == SYNC -> CNT_HI; clear WordCount and running sum.
  - Any other accepted byte is discarded; stay in IDLE.
- CNT_HI: accept byte -> store as N[15:8], add to sum -> CNT_LO.
- CNT_LO: accept byte -> store as N[7:0], add to sum.
  - N == 0 or N > 2**ADDR_W -> ERROR.
  - Otherwise -> DATA_HI.
- DATA_HI: accept byte -> hold as high byte, add to sum -> DATA_LO.
- DATA_LO: accept byte, add to sum. On the next cycle:
  - IMemWrite=1, IMemData={high,low}, IMemAddr=WordCount[ADDR_W-1:0].
  - WordCount increments in that same cycle.
  - If this is word N -> CHECK; else -> DATA_HI.
  - The write cycle never stalls ByteReady; a byte may be accepted in the same cycle.
- IMemWrite is 1 only in the cycle after a DATA_LO acceptance; 0 otherwise.
- IMemAddr and IMemData hold their last values between writes.
- CHECK: accept byte.
  - Byte == sum[7:0] -> RUN; CpuRstN goes 1 in the first RUN cycle.
  - Otherwise -> ERROR.
- RUN: CpuRstN=1, Done=1.
- ERROR: CpuRstN=0, Error=1. Words already written are not undone.
- Restart=1 in RUN or ERROR -> IDLE on the next edge; CpuRstN=0 from that edge. Restart is ignored in all other states.
- CpuRstN is 0 in every state except RUN.
- ByteValid gaps of any length are legal in any receiving state; no timeout.
- Address never exceeds 2**ADDR_W-1; a maximum-length frame ends with the write to address 2**ADDR_W-1.

Test Plan:
1. Normal frame: A5 00 02 12 34 AB CD C0 ->
   - write 0x1234 @0, then 0xABCD @1, one-cycle strobes;
   - WordCount=2; CpuRstN 0->1 one cycle after C0 is accepted; Done=1.
2. Garbage before sync: 00 FF 5A, then the scenario-1 frame ->
   - first three bytes discarded (StateOut=000 throughout);
   - result identical to scenario 1.
3. Bad checksum: scenario-1 frame with final byte C1 ->
   - both writes occur; Error=1, StateOut=111, CpuRstN stays 0, ByteReady=0.
4. Count bounds with ADDR_W=8:
   - A5 00 00 -> ERROR after the third byte, no writes;
   - A5 01 01 -> ERROR, no writes;
   - A5 01 00, 256 words, correct checksum -> last write @0xFF, WordCount=256, RUN.
5. Backpressure and gaps:
   - scenario 1 with random 0-5 idle cycles between bytes -> identical writes and release.
   - Restart=1 in RUN -> IDLE next cycle, CpuRstN=0; a new frame then loads again from address 0.
6. Reset mid-frame: assert Rst=0 mid-cycle while in DATA_LO ->
   - outputs reset immediately (IMemWrite 0, CpuRstN 0, StateOut 000) without waiting for Clk;
   - after release, a fresh frame loads correctly.
